// File: rtl/decode_pkg.sv
// Shared decode definitions: format codes, functional-unit codes and the
// packed decoded-instruction record passed from decode stage 2 to issue.
package decode_pkg;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned XOPCODE_W = 10;
  localparam int unsigned FORMAT_W  = 5;
  localparam int unsigned FU_W      = 3;
  localparam int unsigned USE_W     = 2;

  // Instruction format codes
  localparam logic [FORMAT_W-1:0] FMT_INVALID = FORMAT_W'(0);
  localparam logic [FORMAT_W-1:0] FMT_A       = FORMAT_W'(1);
  localparam logic [FORMAT_W-1:0] FMT_D       = FORMAT_W'(3);
  localparam logic [FORMAT_W-1:0] FMT_DQ      = FORMAT_W'(4);
  localparam logic [FORMAT_W-1:0] FMT_DS      = FORMAT_W'(5);
  localparam logic [FORMAT_W-1:0] FMT_MD      = FORMAT_W'(9);
  localparam logic [FORMAT_W-1:0] FMT_X       = FORMAT_W'(15);
  localparam logic [FORMAT_W-1:0] FMT_XO      = FORMAT_W'(19);
  localparam logic [FORMAT_W-1:0] FMT_Z23     = FORMAT_W'(25);

  // Functional-unit codes
  localparam logic [FU_W-1:0] FU_INT    = FU_W'(0);
  localparam logic [FU_W-1:0] FU_LDST   = FU_W'(1);
  localparam logic [FU_W-1:0] FU_BRANCH = FU_W'(2);
  localparam logic [FU_W-1:0] FU_FP     = FU_W'(3);
  localparam logic [FU_W-1:0] FU_VECTOR = FU_W'(4);
  localparam logic [FU_W-1:0] FU_SYSTEM = FU_W'(5);

  // Decoded instruction record, MSB first
  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [OPCODE_W-1:0]  opcode;
    logic [XOPCODE_W-1:0] xopcode;
    logic                 xopcode_en;
    logic [FU_W-1:0]      fu_code;
    logic [FORMAT_W-1:0]  format;
    logic [IMM_W-1:0]     imm;
    logic                 imm_en;
    logic [REG_W-1:0]     reg1;
    logic [REG_W-1:0]     reg2;
    logic [REG_W-1:0]     reg3;
    logic [USE_W-1:0]     reg1_use;
    logic [USE_W-1:0]     reg2_use;
    logic [USE_W-1:0]     reg3_use;
    logic                 reg1_en;
    logic                 reg2_en;
    logic                 reg3_en;
    logic                 reg3_is_imm;
    logic                 reg2_val_or_zero;
    logic                 bit1;
    logic                 bit2;
    logic                 bit1_en;
    logic                 bit2_en;
  } decoded_instr_t;

  localparam int unsigned REC_W      = $bits(decoded_instr_t);
  localparam int unsigned ADDR_LSB   = REC_W - ADDR_W;
  localparam int unsigned OPCODE_LSB = ADDR_LSB - OPCODE_W;
  localparam int unsigned XOP_LSB    = OPCODE_LSB - XOPCODE_W;

endpackage

// File: rtl/decode_queue_ram.sv
// Queue storage: DEPTH x REC_W register array, one write port, one registered
// read port. A same-cycle write to the read address is forwarded so the
// registered output always reflects the entry at raddr after the edge.
// Ports: clock_i, reset_i (sync, active-low, clears rdata), we/waddr/wdata,
// raddr, rdata.
module decode_queue_ram
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 we,
  input  logic [PTR_W-1:0]     waddr,
  input  decoded_instr_t       wdata,
  input  logic [PTR_W-1:0]     raddr,
  output decoded_instr_t       rdata
);

  decoded_instr_t mem [DEPTH];

  // Storage write and registered, write-forwarding read
  always_ff @(posedge clock_i) begin
    if (we) mem[waddr] <= wdata;
    if (!reset_i)                 rdata <= '0;
    else if (we && waddr == raddr) rdata <= wdata;
    else                          rdata <= mem[raddr];
  end

endmodule

// File: rtl/decode_issue_queue.sv
// In-order queue between decode stage 2 and issue. Head entry is presented
// from a register (no input-to-output path). stall_o asserts early so that
// SKID in-flight decode instructions still fit. overflow_o is sticky.
// Ports: clock_i/reset_i (sync, active-low), flush_i, enable_i + decoded
// fields (*_i), head fields (*_o), valid_o/ready_i handshake, stall_o,
// count_o occupancy, overflow_o.
module decode_issue_queue
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SKID  = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 enable_i,
  input  logic [IMM_W-1:0]     imm_i,
  input  logic                 immEnable_i,
  input  logic [REG_W-1:0]     reg1_i,
  input  logic [REG_W-1:0]     reg2_i,
  input  logic [REG_W-1:0]     reg3_i,
  input  logic [USE_W-1:0]     reg1Use_i,
  input  logic [USE_W-1:0]     reg2Use_i,
  input  logic [USE_W-1:0]     reg3Use_i,
  input  logic                 reg1Enable_i,
  input  logic                 reg2Enable_i,
  input  logic                 reg3Enable_i,
  input  logic                 reg3IsImmediate_i,
  input  logic                 reg2ValOrZero_i,
  input  logic                 bit1_i,
  input  logic                 bit2_i,
  input  logic                 bit1Enable_i,
  input  logic                 bit2Enable_i,
  input  logic [ADDR_W-1:0]    instructionAddress_i,
  input  logic [OPCODE_W-1:0]  opcode_i,
  input  logic [XOPCODE_W-1:0] xOpcode_i,
  input  logic                 xOpcodeEnable_i,
  input  logic [FU_W-1:0]      functionalUnitCode_i,
  input  logic [FORMAT_W-1:0]  instructionFormat_i,
  output logic [IMM_W-1:0]     imm_o,
  output logic                 immEnable_o,
  output logic [REG_W-1:0]     reg1_o,
  output logic [REG_W-1:0]     reg2_o,
  output logic [REG_W-1:0]     reg3_o,
  output logic [USE_W-1:0]     reg1Use_o,
  output logic [USE_W-1:0]     reg2Use_o,
  output logic [USE_W-1:0]     reg3Use_o,
  output logic                 reg1Enable_o,
  output logic                 reg2Enable_o,
  output logic                 reg3Enable_o,
  output logic                 reg3IsImmediate_o,
  output logic                 reg2ValOrZero_o,
  output logic                 bit1_o,
  output logic                 bit2_o,
  output logic                 bit1Enable_o,
  output logic                 bit2Enable_o,
  output logic [ADDR_W-1:0]    instructionAddress_o,
  output logic [OPCODE_W-1:0]  opcode_o,
  output logic [XOPCODE_W-1:0] xOpcode_o,
  output logic                 xOpcodeEnable_o,
  output logic [FU_W-1:0]      functionalUnitCode_o,
  output logic [FORMAT_W-1:0]  instructionFormat_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 stall_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                 overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);

  logic [PTR_W-1:0] head_q, tail_q, head_nxt, tail_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             valid_q, stall_q, ovf_q;
  logic             pop_c, push_c, drop_c, we_c;
  decoded_instr_t   wdata, rdata;

  // Pack incoming fields into the stored record
  always_comb begin
    wdata                  = '0;
    wdata.addr             = instructionAddress_i;
    wdata.opcode           = opcode_i;
    wdata.xopcode          = xOpcode_i;
    wdata.xopcode_en       = xOpcodeEnable_i;
    wdata.fu_code          = functionalUnitCode_i;
    wdata.format           = instructionFormat_i;
    wdata.imm              = imm_i;
    wdata.imm_en           = immEnable_i;
    wdata.reg1             = reg1_i;
    wdata.reg2             = reg2_i;
    wdata.reg3             = reg3_i;
    wdata.reg1_use         = reg1Use_i;
    wdata.reg2_use         = reg2Use_i;
    wdata.reg3_use         = reg3Use_i;
    wdata.reg1_en          = reg1Enable_i;
    wdata.reg2_en          = reg2Enable_i;
    wdata.reg3_en          = reg3Enable_i;
    wdata.reg3_is_imm      = reg3IsImmediate_i;
    wdata.reg2_val_or_zero = reg2ValOrZero_i;
    wdata.bit1             = bit1_i;
    wdata.bit2             = bit2_i;
    wdata.bit1_en          = bit1Enable_i;
    wdata.bit2_en          = bit2Enable_i;
  end

  // Handshake, pointer and occupancy next-state; a pop on a full queue
  // frees the slot the same-edge push lands in
  always_comb begin
    pop_c     = valid_q && ready_i;
    push_c    = enable_i && ((count_q != FULL_CNT) || pop_c);
    drop_c    = enable_i && (count_q == FULL_CNT) && !pop_c && !flush_i;
    we_c      = push_c && !flush_i;
    head_nxt  = head_q + PTR_W'(pop_c);
    tail_nxt  = tail_q + PTR_W'(push_c);
    count_nxt = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (flush_i) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
    end
  end

  // State registers
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      count_q <= count_nxt;
      valid_q <= (count_nxt != '0);
      stall_q <= (count_nxt >= STALL_CNT);
      if (drop_c) ovf_q <= 1'b1;
    end
  end

  // Reading at the next head keeps the registered output on the head entry
  decode_queue_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we      (we_c),
    .waddr   (tail_q),
    .wdata   (wdata),
    .raddr   (head_nxt),
    .rdata   (rdata)
  );

  assign valid_o    = valid_q;
  assign stall_o    = stall_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

  assign instructionAddress_o = rdata.addr;
  assign opcode_o             = rdata.opcode;
  assign xOpcode_o            = rdata.xopcode;
  assign xOpcodeEnable_o      = rdata.xopcode_en;
  assign functionalUnitCode_o = rdata.fu_code;
  assign instructionFormat_o  = rdata.format;
  assign imm_o                = rdata.imm;
  assign immEnable_o          = rdata.imm_en;
  assign reg1_o               = rdata.reg1;
  assign reg2_o               = rdata.reg2;
  assign reg3_o               = rdata.reg3;
  assign reg1Use_o            = rdata.reg1_use;
  assign reg2Use_o            = rdata.reg2_use;
  assign reg3Use_o            = rdata.reg3_use;
  assign reg1Enable_o         = rdata.reg1_en;
  assign reg2Enable_o         = rdata.reg2_en;
  assign reg3Enable_o         = rdata.reg3_en;
  assign reg3IsImmediate_o    = rdata.reg3_is_imm;
  assign reg2ValOrZero_o      = rdata.reg2_val_or_zero;
  assign bit1_o               = rdata.bit1;
  assign bit2_o               = rdata.bit2;
  assign bit1Enable_o         = rdata.bit1_en;
  assign bit2Enable_o         = rdata.bit2_en;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed scenarios then random traffic, all
// checked every cycle against a queue-based reference model.
module tb_decode_issue_queue;
  import decode_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SKID  = 2;

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  logic flush_i = 1'b0;
  logic enable_i = 1'b0;
  logic ready_i = 1'b0;
  decoded_instr_t in_rec = '0;
  wire decoded_instr_t out_rec;
  logic valid_o, stall_o, overflow_o;
  logic [$clog2(DEPTH):0] count_o;

  always #5 clock_i = ~clock_i;

  decode_issue_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .flush_i              (flush_i),
    .enable_i             (enable_i),
    .imm_i                (in_rec.imm),
    .immEnable_i          (in_rec.imm_en),
    .reg1_i               (in_rec.reg1),
    .reg2_i               (in_rec.reg2),
    .reg3_i               (in_rec.reg3),
    .reg1Use_i            (in_rec.reg1_use),
    .reg2Use_i            (in_rec.reg2_use),
    .reg3Use_i            (in_rec.reg3_use),
    .reg1Enable_i         (in_rec.reg1_en),
    .reg2Enable_i         (in_rec.reg2_en),
    .reg3Enable_i         (in_rec.reg3_en),
    .reg3IsImmediate_i    (in_rec.reg3_is_imm),
    .reg2ValOrZero_i      (in_rec.reg2_val_or_zero),
    .bit1_i               (in_rec.bit1),
    .bit2_i               (in_rec.bit2),
    .bit1Enable_i         (in_rec.bit1_en),
    .bit2Enable_i         (in_rec.bit2_en),
    .instructionAddress_i (in_rec.addr),
    .opcode_i             (in_rec.opcode),
    .xOpcode_i            (in_rec.xopcode),
    .xOpcodeEnable_i      (in_rec.xopcode_en),
    .functionalUnitCode_i (in_rec.fu_code),
    .instructionFormat_i  (in_rec.format),
    .imm_o                (out_rec.imm),
    .immEnable_o          (out_rec.imm_en),
    .reg1_o               (out_rec.reg1),
    .reg2_o               (out_rec.reg2),
    .reg3_o               (out_rec.reg3),
    .reg1Use_o            (out_rec.reg1_use),
    .reg2Use_o            (out_rec.reg2_use),
    .reg3Use_o            (out_rec.reg3_use),
    .reg1Enable_o         (out_rec.reg1_en),
    .reg2Enable_o         (out_rec.reg2_en),
    .reg3Enable_o         (out_rec.reg3_en),
    .reg3IsImmediate_o    (out_rec.reg3_is_imm),
    .reg2ValOrZero_o      (out_rec.reg2_val_or_zero),
    .bit1_o               (out_rec.bit1),
    .bit2_o               (out_rec.bit2),
    .bit1Enable_o         (out_rec.bit1_en),
    .bit2Enable_o         (out_rec.bit2_en),
    .instructionAddress_o (out_rec.addr),
    .opcode_o             (out_rec.opcode),
    .xOpcode_o            (out_rec.xopcode),
    .xOpcodeEnable_o      (out_rec.xopcode_en),
    .functionalUnitCode_o (out_rec.fu_code),
    .instructionFormat_o  (out_rec.format),
    .valid_o              (valid_o),
    .ready_i              (ready_i),
    .stall_o              (stall_o),
    .count_o              (count_o),
    .overflow_o           (overflow_o)
  );

  // Reference model state
  decoded_instr_t model_q[$];
  logic           m_ovf = 1'b0;
  int             n_vec = 0;
  int             n_err = 0;

  task automatic check_eq(input string tag, input logic [REC_W-1:0] got,
                          input logic [REC_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic decoded_instr_t rand_rec();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return decoded_instr_t'(t[REC_W-1:0]);
  endfunction

  // Apply one cycle of stimulus, advance the model, check all outputs
  task automatic cycle(input logic rst_n, input logic fl, input logic en,
                       input logic rdy, input decoded_instr_t rec);
    logic had_entry;
    reset_i  = rst_n;
    flush_i  = fl;
    enable_i = en;
    ready_i  = rdy;
    in_rec   = rec;
    @(posedge clock_i);
    if (!rst_n) begin
      model_q.delete();
      m_ovf = 1'b0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      had_entry = (model_q.size() != 0);
      if (had_entry && rdy) void'(model_q.pop_front());
      if (en) begin
        if (model_q.size() < DEPTH) model_q.push_back(rec);
        else m_ovf = 1'b1;
      end
    end
    #1;
    check_eq("valid", REC_W'(valid_o), REC_W'(model_q.size() != 0));
    check_eq("count", REC_W'(count_o), REC_W'(model_q.size()));
    check_eq("stall", REC_W'(stall_o), REC_W'(model_q.size() >= DEPTH - SKID));
    check_eq("overflow", REC_W'(overflow_o), REC_W'(m_ovf));
    if (!rst_n) check_eq("reset_fields", REC_W'(out_rec), '0);
    else if (model_q.size() != 0) check_eq("head", REC_W'(out_rec), REC_W'(model_q[0]));
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, rdy, rand_rec());
  endtask

  task automatic push_n(input logic rdy, input int n, input int base);
    decoded_instr_t r;
    for (int i = 0; i < n; i++) begin
      r = rand_rec();
      r.addr = ADDR_W'(base + i);
      cycle(1'b1, 1'b0, 1'b1, rdy, r);
    end
  endtask

  initial begin
    decoded_instr_t d;
    logic rdy_bias;

    // Reset
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, rand_rec());

    // Single D-format instruction
    d = '0;
    d.format = FMT_D; d.addr = 64'h1000; d.opcode = 6'd14;
    d.reg1 = 5'd3; d.reg2 = 5'd1; d.imm = 16'h0010;
    d.reg1_en = 1'b1; d.reg2_en = 1'b1; d.imm_en = 1'b1; d.fu_code = FU_LDST;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, d);
    idle(1'b1, 2);

    // Fill with back-pressure, 9th push overflows, then drain
    push_n(1'b0, 9, 'h100);
    idle(1'b1, 10);

    // Full queue with simultaneous push and pop across wrap
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push_n(1'b0, 8, 'h200);
    push_n(1'b1, 20, 'h300);
    idle(1'b1, 9);

    // Flush priority over push and pop
    push_n(1'b0, 5, 'h400);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, rand_rec());
    push_n(1'b0, 1, 'h500);
    idle(1'b1, 2);

    // Reset mid-stream
    push_n(1'b0, 4, 'h600);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, rand_rec());
    push_n(1'b1, 3, 'h700);
    idle(1'b1, 2);

    // Head held stable under back-pressure while pushes arrive
    push_n(1'b0, 1, 'h800);
    push_n(1'b0, 5, 'h900);
    idle(1'b1, 7);

    // Random traffic with phases of varying back-pressure
    rdy_bias = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) rdy_bias = ~rdy_bias;
      cycle($urandom_range(0, 299) != 0,
            $urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0,
            rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            rand_rec());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Buffers fully decoded instructions leaving decode stage 2 and presents them in order to the issue stage through a valid/ready handshake.
- Decode stage 2 has no ready input, so this block asserts an early stall (`stall_o`) that leaves room for instructions already in flight upstream.
- Sits directly downstream of decode stage 2 and upstream of issue/register-read.

Parameters:
- depth, 8, number of queue entries; power of two, >= 4.
- skid, 2, free entries reserved for in-flight decode instructions once `stall_o` asserts.
- addressSize, 64, instruction address width.
- opcodeWidth, 6, primary opcode width.
- regWidth, 5, register index width.
- immWidth, 16, immediate width.
- xOpcodeWidth, 10, extended opcode width.
- formatIndexRange, 5, instruction format code width.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-low.
- flush_i  in  1  discard all entries (branch mispredict/exception).
- enable_i  in  1  decoded instruction valid this cycle.
- imm_i  in  immWidth  immediate.
- immEnable_i  in  1  immediate used.
- reg1_i, reg2_i, reg3_i  in  regWidth each  register indices.
- reg1Use_i, reg2Use_i, reg3Use_i  in  2 each  register use codes.
- reg1Enable_i, reg2Enable_i, reg3Enable_i  in  1 each  register valid.
- reg3IsImmediate_i, reg2ValOrZero_i  in  1 each  operand modifiers.
- bit1_i, bit2_i, bit1Enable_i, bit2Enable_i  in  1 each  flag bits and their valids.
- instructionAddress_i  in  addressSize  instruction address.
- opcode_i  in  opcodeWidth  primary opcode.
- xOpcode_i  in  xOpcodeWidth  extended opcode.
- xOpcodeEnable_i  in  1  extended opcode valid.
- functionalUnitCode_i  in  3  target functional unit.
- instructionFormat_i  in  formatIndexRange  instruction format code.
- `*_o` counterparts of every field above (same widths)  out  head entry fields.
- valid_o  out  1  head entry valid.
- ready_i  in  1  issue stage accepts head.
- stall_o  out  1  upstream must stop fetch/decode.
- count_o  out  log2(depth)+1  current occupancy.
- overflow_o  out  1  sticky error flag: push attempted while full.

Behaviour:
- Reset (`reset_i` == 0 at a clock edge):
  - head, tail and count cleared.
  - `valid_o`, `stall_o`, `overflow_o` = 0; all field outputs = 0.
  - Reset mid-operation discards all contents, same as flush.
- Push: `enable_i` == 1 and not full writes all fields to `entry[tail]`, then tail increments modulo depth.
- Pop: `valid_o` && `ready_i` at an edge retires the head, then head increments modulo depth.
- Output timing:
  - Field outputs are the registered head entry; no combinational path from `*_i` to `*_o`.
  - Minimum latency is 1 cycle: an instruction pushed at edge N into an empty queue is on the outputs with `valid_o` = 1 after edge N.
  - `*_o` hold stable while `valid_o` && !`ready_i`.
  - Field values are don't-care when `valid_o` = 0.
- Simultaneous push and pop:
  - Non-empty queue: both occur, count unchanged.
  - Empty queue: push only; no bypass; `valid_o` rises next cycle.
  - Full queue: the pop frees a slot and the push is accepted in the same edge, count unchanged, no overflow.
- Occupancy outputs:
  - `count_o` registered; `valid_o` = (count != 0).
  - `stall_o` registered, asserted when next count >= depth - skid, deasserted when next count < depth - skid.
- Overflow: push while full with no simultaneous pop drops the instruction and sets `overflow_o`; it clears only on reset.
- Flush:
  - `flush_i` has priority over push and pop in the same edge: head = tail = count = 0.
  - Next cycle `valid_o` = 0 and `stall_o` = 0; the instruction presented with the flush is dropped.
  - `overflow_o` unaffected.
- Wrap-around: pointers are log2(depth) bits; full/empty are decided by count, not by pointer compare.

Decomposition:
- Shared package (`decode_pkg`):
  - format codes: INVALID=0, A=1 … D=3, DQ=4, DS=5, MD=9, X=15, XO=19 … Z23=25.
  - functional-unit code constants.
  - packed decoded-instruction record width and field offsets, reused by decode stage 2 and issue.
- One sub-module, `decode_queue_ram`: depth × recordWidth register array with one write port and one registered read port.
- Pointer, count, stall and flag logic live in the top module.

Test Plan:
- Single instruction: push one D-format instruction (addr 0x1000, opcode 14, reg1=3, reg2=1, imm 0x0010) with `ready_i`=1 -> `valid_o`=1 one cycle later with identical fields; empty the next cycle; `count_o` 0→1→0.
- Fill with back-pressure: depth=8, skid=2, `ready_i`=0, push 8 instructions -> `stall_o` rises the cycle count reaches 6; count=8; a 9th push sets `overflow_o`=1; draining yields addresses in push order with the 9th absent.
- Full-queue push/pop: count=8, `ready_i`=1 and push in the same cycle -> accepted, count stays 8, `overflow_o` stays 0, order preserved across wrap (20 more pushes).
- Flush priority: count=5 and flush with a simultaneous push and `ready_i`=1 -> next cycle `valid_o`=0, count=0, `stall_o`=0; a subsequent push appears alone.
- Reset mid-stream: count=4, `valid_o`=1, `reset_i`=0 for one edge -> all outputs 0; queue behaves as empty afterward.
- Hold-stable check: `valid_o`=1, `ready_i`=0 for 5 cycles while new pushes arrive -> head fields unchanged every cycle.
